// File: rtl/dds_sweep_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dds_sweep_ctrl_if                                          |
// | Brief   : Control/config and DDS-drive bundle for dds_sweep_ctrl.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dds_sweep_ctrl_if #(
    parameter int M  = 32,
    parameter int NW = 12,
    parameter int DW = 16
);
    logic          ic_start;
    logic          ic_abort;
    logic          ic_loop;
    logic          ic_zc_align;
    logic [M-1:0]  id_f_start;
    logic [M-1:0]  id_f_step;
    logic [NW-1:0] id_n_steps;
    logic [DW-1:0] id_dwell;
    logic          ic_zero_crossing;
    logic [M-1:0]  od_p_ac;
    logic          oc_rst_ac;
    logic          oc_en_ac;
    logic          oc_val_data;
    logic          oc_busy;
    logic          oc_done;
    logic          oc_zc_timeout;
    logic [NW-1:0] od_step_idx;

    modport master (
        output ic_start, ic_abort, ic_loop, ic_zc_align, id_f_start, id_f_step,
               id_n_steps, id_dwell, ic_zero_crossing,
        input  od_p_ac, oc_rst_ac, oc_en_ac, oc_val_data, oc_busy, oc_done,
               oc_zc_timeout, od_step_idx
    );

    modport slave (
        input  ic_start, ic_abort, ic_loop, ic_zc_align, id_f_start, id_f_step,
               id_n_steps, id_dwell, ic_zero_crossing,
        output od_p_ac, oc_rst_ac, oc_en_ac, oc_val_data, oc_busy, oc_done,
               oc_zc_timeout, od_step_idx
    );
endinterface
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dds_sweep_ctrl                                             |
// | Brief   : Stepped-frequency sweep sequencer driving a DDS core.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dds_sweep_ctrl #(
    parameter int M  = 32,
    parameter int NW = 12,
    parameter int DW = 16
) (
    input  wire logic        clk,
    input  wire logic        ic_rst_n,
    dds_sweep_ctrl_if.slave  bus
);
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_CLEAR   = 3'd1;
    localparam state_t c_ST_RUN     = 3'd2;
    localparam state_t c_ST_WAIT_ZC = 3'd3;
    localparam state_t c_ST_DONE    = 3'd4;

    state_t        r_state, w_state;
    logic [M-1:0]  r_p_ac, w_p_ac;
    logic [NW-1:0] r_idx, w_idx;
    logic [DW-1:0] r_cnt, w_cnt;
    logic          w_zc_to;

    logic [M-1:0]  r_f_start, r_f_step;
    logic [NW-1:0] r_n_steps;
    logic [DW-1:0] r_dwell_m1;
    logic          r_loop, r_zc_align;
    logic          w_accept;
    logic [DW-1:0] w_dwell_in_m1;

    logic          r_rst_ac, r_en_ac, r_busy, r_done, r_zc_to;

    // A programmed dwell of 0 behaves like 1, so D-1 saturates at 0
    assign w_dwell_in_m1 = (bus.id_dwell == '0) ? '0 : bus.id_dwell - 1'b1;

    always_comb begin
        w_state  = r_state;
        w_p_ac   = r_p_ac;
        w_idx    = r_idx;
        w_cnt    = r_cnt;
        w_zc_to  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.ic_start) begin
                    w_accept = 1'b1;
                    w_state  = c_ST_CLEAR;
                end
            end
            c_ST_CLEAR: begin
                w_p_ac  = r_f_start;
                w_idx   = '0;
                w_cnt   = r_dwell_m1;
                w_state = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                end else if (r_idx == r_n_steps) begin
                    w_state = r_loop ? c_ST_CLEAR : c_ST_DONE;
                end else if (r_zc_align) begin
                    w_cnt   = r_dwell_m1;
                    w_state = c_ST_WAIT_ZC;
                end else begin
                    w_p_ac = r_p_ac + r_f_step;
                    w_idx  = r_idx + 1'b1;
                    w_cnt  = r_dwell_m1;
                end
            end
            c_ST_WAIT_ZC: begin
                // A crossing coinciding with expiry wins: step without a timeout pulse
                if (bus.ic_zero_crossing || (r_cnt == '0)) begin
                    w_p_ac  = r_p_ac + r_f_step;
                    w_idx   = r_idx + 1'b1;
                    w_cnt   = r_dwell_m1;
                    w_zc_to = ~bus.ic_zero_crossing;
                    w_state = c_ST_RUN;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            c_ST_DONE: begin
                w_state = c_ST_IDLE;
            end
            default: begin
                w_state = c_ST_IDLE;
            end
        endcase

        if (bus.ic_abort) begin
            w_state  = c_ST_IDLE;
            w_zc_to  = 1'b0;
            w_accept = 1'b0;
        end
        if (w_state == c_ST_IDLE) begin
            w_p_ac = '0;
            w_idx  = '0;
        end
        if (w_state == c_ST_CLEAR) begin
            w_idx = '0;
        end
    end

    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_state  <= c_ST_IDLE;
            r_p_ac   <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_rst_ac <= 1'b1;
            r_en_ac  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zc_to  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_p_ac   <= w_p_ac;
            r_idx    <= w_idx;
            r_cnt    <= w_cnt;
            r_rst_ac <= (w_state == c_ST_IDLE) || (w_state == c_ST_CLEAR);
            r_en_ac  <= (w_state == c_ST_RUN) || (w_state == c_ST_WAIT_ZC);
            r_busy   <= (w_state == c_ST_CLEAR) || (w_state == c_ST_RUN) ||
                        (w_state == c_ST_WAIT_ZC);
            r_done   <= (w_state == c_ST_DONE);
            r_zc_to  <= w_zc_to;
        end
    end

    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_f_start  <= '0;
            r_f_step   <= '0;
            r_n_steps  <= '0;
            r_dwell_m1 <= '0;
            r_loop     <= 1'b0;
            r_zc_align <= 1'b0;
        end else if (w_accept) begin
            r_f_start  <= bus.id_f_start;
            r_f_step   <= bus.id_f_step;
            r_n_steps  <= bus.id_n_steps;
            r_dwell_m1 <= w_dwell_in_m1;
            r_loop     <= bus.ic_loop;
            r_zc_align <= bus.ic_zc_align;
        end
    end

    assign bus.od_p_ac       = r_p_ac;
    assign bus.oc_rst_ac     = r_rst_ac;
    assign bus.oc_en_ac      = r_en_ac;
    assign bus.oc_val_data   = r_en_ac;
    assign bus.oc_busy       = r_busy;
    assign bus.oc_done       = r_done;
    assign bus.oc_zc_timeout = r_zc_to;
    assign bus.od_step_idx   = r_idx;
endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dds_sweep_ctrl                                          |
// | Brief   : Directed sweeps checked against a tone-list model.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dds_sweep_ctrl;
    localparam int M  = 32;
    localparam int NW = 12;
    localparam int DW = 16;

    logic clk      = 1'b0;
    logic ic_rst_n = 1'b0;
    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.M(M), .NW(NW), .DW(DW)) bus ();
    dds_sweep_ctrl #(.M(M), .NW(NW), .DW(DW)) dut (
        .clk      (clk),
        .ic_rst_n (ic_rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [M-1:0] p;
        bit chk_p, rst, en, busy, done, to;
        int idx;
    } rec_t;

    rec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    logic [M-1:0] c_fs, c_fstep;
    int           c_n, c_dw;
    bit           c_lp, c_al;
    bit           zc_s[64];
    logic [M-1:0] tr_p[64];
    bit           tr_rst[64], tr_en[64], tr_busy[64], tr_done[64], tr_to[64];
    int           nrec;

    function automatic rec_t mk(logic [M-1:0] p, bit cp, bit rst, bit en, bit busy,
                                bit done, bit to, int idx);
        rec_t r;
        r.p = p; r.chk_p = cp; r.rst = rst; r.en = en; r.busy = busy;
        r.done = done; r.to = to; r.idx = idx;
        return r;
    endfunction

    // Expected per-cycle trace from the start: CLEAR, then each tone held D cycles,
    // optional zero-crossing waits between tones, then DONE (or another CLEAR).
    task automatic build_model(input int limit, output int n);
        int d;
        bit to_flag, hit;
        logic [M-1:0] p;
        d = (c_dw == 0) ? 1 : c_dw;
        n = 0;
        p = c_fs;
        while (n < limit) begin
            exp_q.push_back(mk('0, 0, 1, 0, 1, 0, 0, 0)); n++;
            to_flag = 0;
            for (int k = 0; k <= c_n && n < limit; k++) begin
                p = c_fs + c_fstep * M'(k);
                for (int j = 0; j < d && n < limit; j++) begin
                    exp_q.push_back(mk(p, 1, 0, 1, 1, 0, (j == 0) && to_flag, k)); n++;
                end
                to_flag = 0;
                if (k < c_n && c_al) begin
                    for (int j = 0; j < d && n < limit; j++) begin
                        hit = (n < 64) ? zc_s[n] : 1'b0;
                        exp_q.push_back(mk(p, 1, 0, 1, 1, 0, 0, k)); n++;
                        if (hit) break;
                        if (j == d - 1) to_flag = 1;
                    end
                end
            end
            if (!c_lp) begin
                if (n < limit) begin
                    exp_q.push_back(mk(p, 1, 0, 0, 0, 1, 0, c_n)); n++;
                end
                break;
            end
        end
    endtask

    always @(negedge clk) begin : cmp
        rec_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = mk('0, 1, 1, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.oc_rst_ac !== e.rst || bus.oc_en_ac !== e.en || bus.oc_val_data !== e.en ||
            bus.oc_busy !== e.busy || bus.oc_done !== e.done || bus.oc_zc_timeout !== e.to ||
            bus.od_step_idx !== NW'(e.idx) || (e.chk_p && bus.od_p_ac !== e.p)) begin
            n_bad++;
            $display("FAIL cycle %0d t=%0t: got p=%h rst=%b en=%b val=%b busy=%b done=%b to=%b idx=%0d; want p=%h rst=%b en=%b busy=%b done=%b to=%b idx=%0d",
                     cyc, $time, bus.od_p_ac, bus.oc_rst_ac, bus.oc_en_ac, bus.oc_val_data,
                     bus.oc_busy, bus.oc_done, bus.oc_zc_timeout, bus.od_step_idx,
                     e.p, e.rst, e.en, e.busy, e.done, e.to, e.idx);
        end
        cyc++;
    end

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic int count(input bit a[64], input int upto);
        int c = 0;
        for (int i = 0; i <= upto; i++) c += int'(a[i]);
        return c;
    endfunction

    task automatic set_cfg(input logic [M-1:0] fs, input logic [M-1:0] fst, input int n,
                           input int dw, input bit lp, input bit al);
        c_fs = fs; c_fstep = fst; c_n = n; c_dw = dw; c_lp = lp; c_al = al;
        for (int i = 0; i < 64; i++) zc_s[i] = 1'b0;
    endtask

    task automatic drive_cfg();
        bus.id_f_start  = c_fs;
        bus.id_f_step   = c_fstep;
        bus.id_n_steps  = NW'(c_n);
        bus.id_dwell    = DW'(c_dw);
        bus.ic_loop     = c_lp;
        bus.ic_zc_align = c_al;
    endtask

    task automatic capture(input int i);
        tr_p[i] = bus.od_p_ac;     tr_rst[i] = bus.oc_rst_ac; tr_en[i] = bus.oc_en_ac;
        tr_busy[i] = bus.oc_busy;  tr_done[i] = bus.oc_done;  tr_to[i] = bus.oc_zc_timeout;
    endtask

    task automatic run(input int limit, input int abort_at, input int busy_start_at);
        @(posedge clk); #2;
        drive_cfg();
        bus.ic_start = 1'b1;
        @(posedge clk); #2;
        bus.ic_start = 1'b0;
        build_model(limit, nrec);
        bus.ic_zero_crossing = zc_s[0];
        capture(0);
        for (int i = 1; i < nrec + 3; i++) begin
            @(posedge clk); #2;
            capture(i);
            bus.ic_zero_crossing = (i < nrec) ? zc_s[i] : 1'b0;
            bus.ic_abort = (i == abort_at);
            bus.ic_start = (i == busy_start_at);
            if (i == 2) begin
                // Reprogramming mid-sweep must not disturb the latched configuration
                bus.id_f_start = ~c_fs;
                bus.id_n_steps = NW'(c_n + 2);
                bus.id_dwell   = DW'(9);
                bus.ic_loop    = ~c_lp;
            end
        end
        bus.ic_abort = 1'b0;
        bus.ic_start = 1'b0;
    endtask

    initial begin
        bus.ic_start = 1'b0; bus.ic_abort = 1'b0; bus.ic_zero_crossing = 1'b0;
        set_cfg('0, '0, 0, 0, 0, 0);
        drive_cfg();
        repeat (2) @(posedge clk);
        #2 ic_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic sweep
        set_cfg(32'h0100_0000, 32'h0080_0000, 3, 4, 0, 0);
        run(1000, -1, -1);
        lit("basic_n_records", 64'(nrec), 64'd18);
        lit("basic_tone0", 64'(tr_p[1]), 64'h0100_0000);
        lit("basic_tone1", 64'(tr_p[5]), 64'h0180_0000);
        lit("basic_tone2", 64'(tr_p[9]), 64'h0200_0000);
        lit("basic_tone3", 64'(tr_p[16]), 64'h0280_0000);
        lit("basic_busy_cycles", 64'(count(tr_busy, nrec + 2)), 64'd17);
        lit("basic_en_cycles", 64'(count(tr_en, nrec + 2)), 64'd16);
        lit("basic_done_count", 64'(count(tr_done, nrec + 2)), 64'd1);
        lit("basic_done_pos", 64'(tr_done[17]), 64'd1);

        // Dwell 0, single tone
        set_cfg(32'h0000_1234, 32'h0000_0001, 0, 0, 0, 0);
        run(1000, -1, -1);
        lit("d0_en_cycles", 64'(count(tr_en, nrec + 2)), 64'd1);
        lit("d0_done_pos", 64'(tr_done[2]), 64'd1);

        // Phase-increment wrap
        set_cfg(32'hFFFF_FF00, 32'h0000_0200, 1, 1, 0, 0);
        run(1000, -1, -1);
        lit("wrap_tone0", 64'(tr_p[1]), 64'hFFFF_FF00);
        lit("wrap_tone1", 64'(tr_p[2]), 64'h0000_0100);

        // Crossing on the third wait cycle
        set_cfg(32'h0000_1000, 32'h0000_0010, 1, 4, 0, 1);
        zc_s[7] = 1'b1;
        run(1000, -1, -1);
        lit("zc_hold", 64'(tr_p[7]), 64'h1000);
        lit("zc_step", 64'(tr_p[8]), 64'h1010);
        lit("zc_no_timeout", 64'(count(tr_to, nrec + 2)), 64'd0);

        // No crossing: forced step with timeout pulse
        set_cfg(32'h0000_1000, 32'h0000_0010, 1, 2, 0, 1);
        run(1000, -1, -1);
        lit("to_hold", 64'(tr_p[4]), 64'h1000);
        lit("to_step", 64'(tr_p[5]), 64'h1010);
        lit("to_pulse", 64'(tr_to[5]), 64'd1);
        lit("to_count", 64'(count(tr_to, nrec + 2)), 64'd1);

        // Crossing coincides with expiry
        set_cfg(32'h0000_1000, 32'h0000_0010, 1, 2, 0, 1);
        zc_s[4] = 1'b1;
        run(1000, -1, -1);
        lit("zc_tie_no_timeout", 64'(count(tr_to, nrec + 2)), 64'd0);

        // Looping sweep, start while busy, then abort
        set_cfg(32'h0000_2000, 32'h0000_0100, 1, 2, 1, 0);
        run(13, 12, 7);
        lit("loop_clear0", 64'(tr_rst[5]), 64'd1);
        lit("loop_run", 64'(tr_rst[6]), 64'd0);
        lit("loop_clear1", 64'(tr_rst[10]), 64'd1);
        lit("loop_no_done", 64'(count(tr_done, nrec + 2)), 64'd0);
        lit("abort_idle", 64'(tr_busy[13]), 64'd0);

        // Start concurrent with abort in IDLE
        @(posedge clk); #2;
        bus.ic_start = 1'b1; bus.ic_abort = 1'b1;
        @(posedge clk); #2;
        bus.ic_start = 1'b0; bus.ic_abort = 1'b0;
        lit("start_abort_busy", 64'(bus.oc_busy), 64'd0);
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-RUN
        set_cfg(32'h0100_0000, 32'h0080_0000, 3, 4, 0, 0);
        @(posedge clk); #2;
        drive_cfg();
        bus.ic_start = 1'b1;
        @(posedge clk); #2;
        bus.ic_start = 1'b0;
        build_model(1000, nrec);
        repeat (6) @(posedge clk);
        #3;
        lit("rst_pre_busy", 64'(bus.oc_busy), 64'd1);
        exp_q.delete();
        ic_rst_n = 1'b0;
        #1;
        lit("rst_p_ac", 64'(bus.od_p_ac), 64'd0);
        lit("rst_rst_ac", 64'(bus.oc_rst_ac), 64'd1);
        lit("rst_en", 64'(bus.oc_en_ac), 64'd0);
        lit("rst_busy", 64'(bus.oc_busy), 64'd0);
        #3 ic_rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
